circuit: RTL and testbench

CIRCUIT -- requirements
Module: circuit

---
 rtl/circuit_pkg.sv | 10 +
 rtl/circuit_filter.sv | 39 +++
 rtl/circuit.sv | 58 +++++
 tb/tb_circuit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/circuit_pkg.sv
// Shared types and constants for the filtered 4-input truth-table circuit.
package circuit_pkg;

  typedef logic [3:0] idx_t;

  localparam logic [15:0] TRUTH_DEFAULT = 16'h6996;
  localparam int          SYNC_DEPTH    = 2;
  localparam int          CNT_W         = 4;

endpackage

// File: rtl/circuit_filter.sv
// Stability filter: accepts a synchronized vector once it has been seen STABLE times in a row.
module circuit_filter
  import circuit_pkg::*;
#(
  parameter int STABLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  idx_t i_samp,
  output idx_t o_idx
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  idx_t             r_cand;
  idx_t             r_idx;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
    end else if (i_samp != r_cand) begin
      r_cand <= i_samp;
      r_cnt  <= ONE_C;
    end else if (r_cnt < STABLE_C) begin
      r_cnt <= r_cnt + ONE_C;
      // Accept on the edge the count reaches STABLE; saturation then holds idx steady.
      if (r_cnt + ONE_C == STABLE_C) begin
        r_idx <= r_cand;
      end
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/circuit.sv
// Top: 2-flop input synchronizer, stability filter, and registered truth-table lookup.
module circuit
  import circuit_pkg::*;
#(
  parameter logic [15:0] TRUTH  = TRUTH_DEFAULT,
  parameter int          STABLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  output logic out
);

  idx_t w_vec;
  idx_t w_idx;
  idx_t r_sync_p0 [SYNC_DEPTH];
  logic r_out_p1;

  assign w_vec = {in4, in3, in2, in1};

  // Stage p0: synchronizer chain, element 0 is s1, last element is s2
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        r_sync_p0[i] <= '0;
      end
    end else begin
      r_sync_p0[0] <= w_vec;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_sync_p0[i] <= r_sync_p0[i-1];
      end
    end
  end

  circuit_filter #(
    .STABLE (STABLE)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .i_samp (r_sync_p0[SYNC_DEPTH-1]),
    .o_idx  (w_idx)
  );

  // Stage p1: output lookup flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p1 <= TRUTH[0];
    end else begin
      r_out_p1 <= TRUTH[w_idx];
    end
  end

  assign out = r_out_p1;

endmodule

// File: tb/tb_circuit.sv
// Randomized and directed bench for circuit against a history-based reference model.
module tb_circuit;

  localparam logic [15:0] T_PAR = 16'h6996;
  localparam logic [15:0] T_AND = 16'h8000;
  localparam int          MAXE  = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       in1, in2, in3, in4;
  logic       out_a, out_b, out_c;
  logic [3:0] v;

  int errors = 0;
  int checks = 0;
  int n      = 0;

  logic [3:0] va [MAXE];
  bit         ra [MAXE];
  int         lr [MAXE];

  assign {in4, in3, in2, in1} = v;

  always #5 clk = ~clk;

  circuit u_dut (
    .clk (clk), .rst (rst), .in1 (in1), .in2 (in2), .in3 (in3), .in4 (in4), .out (out_a)
  );

  circuit #(.TRUTH(T_AND)) u_dut_and (
    .clk (clk), .rst (rst), .in1 (in1), .in2 (in2), .in3 (in3), .in4 (in4), .out (out_b)
  );

  circuit #(.STABLE(3)) u_dut_s3 (
    .clk (clk), .rst (rst), .in1 (in1), .in2 (in2), .in3 (in3), .in4 (in4), .out (out_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, n - 1, got, exp);
    end
  endtask

  // Value the filter sees (s2 contents) just before edge m.
  function automatic logic [3:0] obs(input int m);
    if (m < 2) return 4'd0;
    if (ra[m-1] || ra[m-2]) return 4'd0;
    return va[m-2];
  endfunction

  // Accepted index after edge m: value of the latest run of st equal
  // observations lying entirely after the most recent reset edge.
  function automatic logic [3:0] idx_after(input int m, input int st);
    int         r;
    logic [3:0] x;
    bit         ok;
    if (ra[m]) return 4'd0;
    r = lr[m];
    for (int e = m; e - st + 1 > r; e--) begin
      x  = obs(e);
      ok = 1'b1;
      for (int k = 1; k < st; k++) begin
        if (obs(e - k) != x) ok = 1'b0;
      end
      if (ok) return x;
    end
    return 4'd0;
  endfunction

  function automatic logic exp_out(input int m, input logic [15:0] truth, input int st);
    logic [3:0] ix;
    if (ra[m]) return truth[0];
    ix = idx_after(m - 1, st);
    return truth[ix];
  endfunction

  task automatic tick();
    int e;
    @(posedge clk);
    e = n;
    if (e >= MAXE) begin
      $display("FAIL edge_budget edge=%0d limit=%0d", e, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    va[e] = v;
    ra[e] = rst;
    lr[e] = rst ? e : ((e > 0) ? lr[e-1] : 0);
    n++;
    #1;
    chk("out_par", {31'd0, out_a}, {31'd0, exp_out(e, T_PAR, 2)});
    chk("out_and", {31'd0, out_b}, {31'd0, exp_out(e, T_AND, 2)});
    chk("out_s3",  {31'd0, out_c}, {31'd0, exp_out(e, T_PAR, 3)});
    chk("idx",     {28'd0, u_dut.u_filter.o_idx}, {28'd0, idx_after(e, 2)});
  endtask

  initial begin
    int hold;
    bit rpulse;
    logic [3:0] c;

    // Reset with all inputs low, then idle.
    v   = 4'd0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out", {31'd0, out_a}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_hold", {31'd0, out_a}, 32'd0);
    end

    // Single steps with explicit latency: edge k loads s1, out changes after k+4.
    v = 4'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lat_v1_early", {31'd0, out_a}, 32'd0);
    end
    tick();
    chk("lat_v1", {31'd0, out_a}, 32'd1);
    v = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lat_v3_early", {31'd0, out_a}, 32'd1);
    end
    tick();
    chk("lat_v3", {31'd0, out_a}, 32'd0);

    // Exhaustive sweep.
    for (int s = 0; s < 16; s++) begin
      v = 4'(s);
      for (int i = 0; i < 8; i++) tick();
      chk("sweep_par", {31'd0, out_a}, {31'd0, T_PAR[s]});
      chk("sweep_and", {31'd0, out_b}, {31'd0, (s == 15) ? 1'b1 : 1'b0});
    end

    // Glitch rejection from v=0.
    v = 4'd0;
    for (int i = 0; i < 10; i++) tick();
    v = 4'd4;
    tick();
    v = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch1_out", {31'd0, out_a}, 32'd0);
    end
    v = 4'd4;
    for (int i = 0; i < 3; i++) tick();
    v = 4'd0;
    for (int i = 0; i < 10; i++) tick();
    chk("glitch3_back", {31'd0, out_a}, 32'd0);

    // Binary-counter stimulus: in1 never stable for two samples.
    c = 4'd0;
    for (int i = 0; i < 64; i++) begin
      v = c;
      tick();
      chk("counter_out", {31'd0, out_a}, 32'd0);
      c = c + 4'd1;
    end

    // Reset in the middle of a count.
    v = 4'd0;
    for (int i = 0; i < 8; i++) tick();
    v = 4'd5;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    chk("mid_idx", {28'd0, u_dut.u_filter.o_idx}, 32'd0);
    chk("mid_out", {31'd0, out_a}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_idx_after", {28'd0, u_dut.u_filter.o_idx}, 32'd5);
    chk("mid_out_after", {31'd0, out_a}, 32'd0);

    // Randomized holds with occasional resets.
    for (int t = 0; t < 300; t++) begin
      v      = 4'($urandom_range(0, 15));
      hold   = $urandom_range(1, 6);
      rpulse = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < hold; i++) begin
        rst = rpulse && (i == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
